// File: rtl/asteroid_render_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : asteroid_pkg                                                |
// | Brief  : Shared constants, draw-window derivation and scheduler      |
// |          state encoding for the asteroid sprite schedulers.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package asteroid_pkg;

  localparam int SCREEN_W    = 320;
  localparam int SCREEN_H    = 240;
  localparam int SPRITE_SIZE = 31;  // sprite edge minus one
  localparam int PIPE_LAT    = 2;   // ROM read plus draw-stage output register

  localparam int COORD_W  = 10;
  localparam int DIR_W    = 6;
  localparam int SPRITE_W = 3;

  // Draw window: every pixel address of the sprite plus the draw pipeline tail.
  function automatic int draw_cycles(input int sprite_size, input int pipe_lat);
    return (sprite_size + 1) * (sprite_size + 1) + pipe_lat;
  endfunction

  localparam int DRAW_CYCLES = draw_cycles(SPRITE_SIZE, PIPE_LAT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EVAL  = 3'd2,
    ST_PLOT  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/asteroid_render_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : asteroid_render_scheduler_if                                |
// | Brief  : Slot-table read port and draw-stage request bundle.         |
// |          master = scheduler side, slave = table/draw-stage side.     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface asteroid_render_scheduler_if
  import asteroid_pkg::*;
#(
  parameter int SLOT_W = 3
);
  // slot table read port (data valid one cycle after slot_idx)
  logic [SLOT_W-1:0]   slot_idx;
  logic                slot_active;
  logic [COORD_W-1:0]  slot_x;
  logic [COORD_W-1:0]  slot_y;
  logic [DIR_W-1:0]    slot_dir;
  logic [SPRITE_W-1:0] slot_sprite;

  // draw-stage request
  logic                plot;
  logic [COORD_W-1:0]  x_pos;
  logic [COORD_W-1:0]  y_pos;
  logic [DIR_W-1:0]    direction;
  logic [SPRITE_W-1:0] sprite_sel;

  modport master (
    output slot_idx, plot, x_pos, y_pos, direction, sprite_sel,
    input  slot_active, slot_x, slot_y, slot_dir, slot_sprite
  );

  modport slave (
    input  slot_idx, plot, x_pos, y_pos, direction, sprite_sel,
    output slot_active, slot_x, slot_y, slot_dir, slot_sprite
  );
endinterface
`default_nettype wire

// File: rtl/asteroid_render_scheduler_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : draw_wait_timer                                             |
// | Brief  : Loadable down-counter with zero flag; holds at zero.        |
// |          Shared by the asteroid, ship and bullet schedulers.         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module draw_wait_timer #(
  parameter int CNT_W = 11
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_value,
  input  wire logic             dec,
  output logic                  zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/asteroid_render_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : asteroid_render_scheduler                                   |
// | Brief  : Walks the asteroid slot table once per frame tick, issues   |
// |          one plot request per visible slot and waits out the draw    |
// |          window before moving on; reports frame completion/overrun.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module asteroid_render_scheduler #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_W      = 3,
  parameter int SPRITE_SIZE = asteroid_pkg::SPRITE_SIZE,
  parameter int PIPE_LAT    = asteroid_pkg::PIPE_LAT,
  parameter int SCREEN_W    = asteroid_pkg::SCREEN_W,
  parameter int SCREEN_H    = asteroid_pkg::SCREEN_H
) (
  input  wire logic                  clk,
  input  wire logic                  reset_n,
  input  wire logic                  frame_start,
  asteroid_render_scheduler_if.master bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun
);
  import asteroid_pkg::*;

  localparam int DRAW_CYCLES = draw_cycles(SPRITE_SIZE, PIPE_LAT);
  localparam int CNT_W       = $clog2(DRAW_CYCLES);
  localparam logic [CNT_W-1:0]  c_wait_load = CNT_W'(DRAW_CYCLES - 1);
  localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(NUM_SLOTS - 1);

  sched_state_e        r_state;
  sched_state_e        w_state_next;
  logic [SLOT_W-1:0]   r_slot_idx;
  logic [COORD_W-1:0]  r_x_pos;
  logic [COORD_W-1:0]  r_y_pos;
  logic [DIR_W-1:0]    r_direction;
  logic [SPRITE_W-1:0] r_sprite_sel;
  logic                r_frame_done;
  logic                w_visible;
  logic                w_timer_zero;

  // Only whole-sprite culling on the anchor point; pixel clipping is downstream.
  assign w_visible = bus.slot_active
                   && (bus.slot_x < COORD_W'(SCREEN_W))
                   && (bus.slot_y < COORD_W'(SCREEN_H));

  draw_wait_timer #(
    .CNT_W (CNT_W)
  ) u_wait_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (r_state == ST_PLOT),
    .load_value (c_wait_load),
    .dec        (r_state == ST_WAIT),
    .zero       (w_timer_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the slot walk.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (frame_start) w_state_next = ST_FETCH;
      ST_FETCH: w_state_next = ST_EVAL;
      ST_EVAL:  w_state_next = w_visible ? ST_PLOT : ST_NEXT;
      ST_PLOT:  w_state_next = ST_WAIT;
      ST_WAIT:  if (w_timer_zero) w_state_next = ST_NEXT;
      ST_NEXT:  w_state_next = (r_slot_idx == c_last_slot) ? ST_DONE : ST_FETCH;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Slot address, latched draw parameters and the end-of-pass pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_idx   <= '0;
      r_x_pos      <= '0;
      r_y_pos      <= '0;
      r_direction  <= '0;
      r_sprite_sel <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= (r_state == ST_DONE);
      if ((r_state == ST_NEXT) && (r_slot_idx != c_last_slot)) begin
        r_slot_idx <= r_slot_idx + SLOT_W'(1);
      end else if (r_state == ST_DONE) begin
        r_slot_idx <= '0;
      end
      // Parameters only change when a slot is accepted, so they hold through WAIT.
      if ((r_state == ST_EVAL) && w_visible) begin
        r_x_pos      <= bus.slot_x;
        r_y_pos      <= bus.slot_y;
        r_direction  <= bus.slot_dir;
        r_sprite_sel <= bus.slot_sprite;
      end
    end
  end

  assign bus.slot_idx   = r_slot_idx;
  assign bus.plot       = (r_state == ST_PLOT);
  assign bus.x_pos      = r_x_pos;
  assign bus.y_pos      = r_y_pos;
  assign bus.direction  = r_direction;
  assign bus.sprite_sel = r_sprite_sel;
  assign busy           = (r_state != ST_IDLE);
  assign frame_done     = r_frame_done;
  // A tick arriving during a pass (DONE included) is dropped but reported.
  assign overrun        = frame_start && busy;

endmodule
`default_nettype wire

// File: tb/tb_asteroid_render_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_asteroid_render_scheduler                                |
// | Brief  : Scoreboard bench: a cost model of the slot walk predicts    |
// |          plot requests, frame_done and overrun; a monitor checks.    |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_asteroid_render_scheduler;

  localparam int NSLOT     = 8;
  localparam int DRAW      = 32 * 32 + 2;   // pixel addresses plus draw pipeline
  localparam int SLOT_COST = 4 + DRAW;      // FETCH, EVAL, PLOT, WAIT..., NEXT
  localparam int SKIP_COST = 3;             // FETCH, EVAL, NEXT

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic frame_start = 1'b0;
  logic busy, frame_done, overrun;

  asteroid_render_scheduler_if #(.SLOT_W(3)) bus ();

  asteroid_render_scheduler #(
    .NUM_SLOTS (NSLOT),
    .SLOT_W    (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slot table contents, read back with one cycle of latency.
  bit t_act [NSLOT];
  int t_x   [NSLOT];
  int t_y   [NSLOT];
  int t_dir [NSLOT];
  int t_spr [NSLOT];

  always @(posedge clk) begin
    bus.slot_active <= t_act[bus.slot_idx];
    bus.slot_x      <= 10'(t_x[bus.slot_idx]);
    bus.slot_y      <= 10'(t_y[bus.slot_idx]);
    bus.slot_dir    <= 6'(t_dir[bus.slot_idx]);
    bus.slot_sprite <= 3'(t_spr[bus.slot_idx]);
  end

  typedef struct {
    int cyc;
    int idx;
    int x;
    int y;
    int dir;
    int spr;
  } plot_t;

  plot_t exp_plot [$];
  plot_t stab_q   [$];
  int    exp_done_cyc  [$];
  int    exp_done_busy [$];
  int    exp_ovr       [$];

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not predicted by model (cycle %0d)", name, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT produces an event.
  plot_t m_e;
  plot_t m_s;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.plot) begin
        if (exp_plot.size() == 0) begin
          flag("unexpected_plot");
        end else begin
          m_e = exp_plot.pop_front();
          check("plot_cycle", cyc, m_e.cyc);
          check("plot_slot_idx", int'(bus.slot_idx), m_e.idx);
          check("plot_x_pos", int'(bus.x_pos), m_e.x);
          check("plot_y_pos", int'(bus.y_pos), m_e.y);
          check("plot_direction", int'(bus.direction), m_e.dir);
          check("plot_sprite_sel", int'(bus.sprite_sel), m_e.spr);
          m_e.cyc = cyc + DRAW;
          stab_q.push_back(m_e);
        end
      end
      if ((stab_q.size() > 0) && (stab_q[0].cyc == cyc)) begin
        m_s = stab_q.pop_front();
        check("hold_x_pos", int'(bus.x_pos), m_s.x);
        check("hold_y_pos", int'(bus.y_pos), m_s.y);
        check("hold_direction", int'(bus.direction), m_s.dir);
        check("hold_sprite_sel", int'(bus.sprite_sel), m_s.spr);
      end
      if (busy) busy_cnt++;
      if (frame_done) begin
        if (exp_done_cyc.size() == 0) begin
          flag("unexpected_frame_done");
        end else begin
          check("frame_done_cycle", cyc, exp_done_cyc.pop_front());
          check("busy_cycles", busy_cnt, exp_done_busy.pop_front());
        end
        busy_cnt = 0;
      end
      if (overrun) begin
        if (exp_ovr.size() == 0) flag("unexpected_overrun");
        else check("overrun_cycle", cyc, exp_ovr.pop_front());
      end
    end
  end

  task automatic set_inactive();
    for (int i = 0; i < NSLOT; i++) begin
      t_act[i] = 1'b0; t_x[i] = 0; t_y[i] = 0; t_dir[i] = 0; t_spr[i] = 0;
    end
  endtask

  task automatic set_onscreen();
    for (int i = 0; i < NSLOT; i++) begin
      t_act[i] = 1'b1;
      t_x[i]   = $urandom_range(0, 319);
      t_y[i]   = $urandom_range(0, 239);
      t_dir[i] = $urandom_range(0, 63);
      t_spr[i] = $urandom_range(0, 7);
    end
  endtask

  task automatic set_mixed();
    for (int i = 0; i < NSLOT; i++) begin
      t_act[i] = 1'($urandom_range(0, 1));
      t_x[i]   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 319) : $urandom_range(300, 1023);
      t_y[i]   = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 239) : $urandom_range(230, 1023);
      t_dir[i] = $urandom_range(0, 63);
      t_spr[i] = $urandom_range(0, 7);
    end
  endtask

  // One render pass. ovr_wait_off: extra tick this many cycles after the first
  // plot (-1 none); ovr_done: extra tick in the final cycle of the pass;
  // rst_slot: pull reset 100 cycles into that slot's draw window (-1 none).
  task automatic run_pass(input int ovr_wait_off, input bit ovr_done, input int rst_slot);
    int s, t, first_plot, rst_c, done_c, end_c, ow, od;
    plot_t p;
    @(posedge clk); #1;
    s = cyc;
    t = s + 1;
    first_plot = -1;
    rst_c = -1;
    for (int i = 0; i < NSLOT; i++) begin
      if (t_act[i] && (t_x[i] < 320) && (t_y[i] < 240)) begin
        p.cyc = t + 2; p.idx = i; p.x = t_x[i]; p.y = t_y[i];
        p.dir = t_dir[i]; p.spr = t_spr[i];
        if (first_plot < 0) first_plot = p.cyc;
        if (i == rst_slot) rst_c = p.cyc + 100;
        if ((rst_slot < 0) || (i <= rst_slot)) exp_plot.push_back(p);
        t += SLOT_COST;
      end else begin
        t += SKIP_COST;
      end
    end
    done_c = t + 1;
    if (rst_c < 0) begin
      exp_done_cyc.push_back(done_c);
      exp_done_busy.push_back(done_c - s - 1);
    end
    ow = ((ovr_wait_off >= 0) && (first_plot >= 0)) ? first_plot + ovr_wait_off : -1;
    od = ovr_done ? t : -1;
    if (ow >= 0) exp_ovr.push_back(ow);
    if (od >= 0) exp_ovr.push_back(od);
    end_c = (rst_c >= 0) ? rst_c : done_c + 2;

    frame_start = 1'b1;
    while (cyc < end_c) begin
      @(posedge clk); #1;
      frame_start = (cyc == ow) || (cyc == od);
      if (cyc == rst_c) begin
        frame_start = 1'b0;
        reset_n = 1'b0;
      end
    end
    frame_start = 1'b0;

    if (rst_c >= 0) begin
      @(negedge clk);
      check("rst_plot", int'(bus.plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_slot_idx", int'(bus.slot_idx), 0);
      check("rst_x_pos", int'(bus.x_pos), 0);
      check("rst_y_pos", int'(bus.y_pos), 0);
      check("rst_direction", int'(bus.direction), 0);
      check("rst_sprite_sel", int'(bus.sprite_sel), 0);
      exp_plot.delete();
      stab_q.delete();
      exp_done_cyc.delete();
      exp_done_busy.delete();
      exp_ovr.delete();
      busy_cnt = 0;
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
    end else begin
      check("plots_outstanding", exp_plot.size(), 0);
      check("hold_outstanding", stab_q.size(), 0);
      check("frame_done_outstanding", exp_done_cyc.size(), 0);
      check("overrun_outstanding", exp_ovr.size(), 0);
    end
  endtask

  initial begin
    set_inactive();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_plot", int'(bus.plot), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_slot_idx", int'(bus.slot_idx), 0);
    check("reset_x_pos", int'(bus.x_pos), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_overrun", int'(overrun), 0);

    // all slots inactive
    set_inactive();
    run_pass(-1, 1'b0, -1);

    // single active slot
    set_inactive();
    t_act[3] = 1'b1; t_x[3] = 100; t_y[3] = 50; t_dir[3] = 12; t_spr[3] = 2;
    run_pass(-1, 1'b0, -1);

    // every slot drawn
    set_onscreen();
    run_pass(-1, 1'b0, -1);

    // screen-edge culling
    set_inactive();
    t_act[0] = 1'b1; t_x[0] = 320; t_y[0] = 10;  t_dir[0] = 1; t_spr[0] = 1;
    t_act[1] = 1'b1; t_x[1] = 10;  t_y[1] = 240; t_dir[1] = 2; t_spr[1] = 2;
    t_act[2] = 1'b1; t_x[2] = 319; t_y[2] = 239; t_dir[2] = 63; t_spr[2] = 7;
    run_pass(-1, 1'b0, -1);

    // ticks arriving during WAIT and during DONE
    set_onscreen();
    run_pass(500, 1'b1, -1);

    // reset in the draw window of slot 4, then a fresh pass
    set_onscreen();
    run_pass(-1, 1'b0, 4);
    set_onscreen();
    run_pass(-1, 1'b0, -1);

    // random mixed tables
    for (int k = 0; k < 2; k++) begin
      set_mixed();
      run_pass(($urandom_range(0, 1) != 0) ? 200 : -1, 1'($urandom_range(0, 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time budget (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/asteroid_render_scheduler.md
Name: asteroid_render_scheduler

Overview:
- Upstream stage of the asteroid sprite drawer.
- On each frame tick it walks the asteroid slot table (register file holding per-asteroid state). For every active, on-screen slot it issues one plot request (position, direction, sprite select) to the draw stage, then waits a fixed draw window before moving on.
- Signals frame completion back to the game-logic/frame controller.

Parameters:
- NUM_SLOTS, 8, number of asteroid slots in the table.
- SLOT_W, 3, width of slot index; must satisfy 2**SLOT_W >= NUM_SLOTS.
- SPRITE_SIZE, 31, sprite edge minus one, matching the draw stage's sprite_size.
- PIPE_LAT, 2, extra cycles of draw-stage pipeline (ROM read plus output register) after the last pixel address.
- DRAW_CYCLES, (SPRITE_SIZE+1)*(SPRITE_SIZE+1)+PIPE_LAT = 1026, length of the wait window per plot.
- SCREEN_W, 320, horizontal visible extent.
- SCREEN_H, 240, vertical visible extent.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse requesting a render pass.
- slot_idx  out  SLOT_W  slot table read address.
- slot_active  in  1  slot occupied; valid 1 cycle after slot_idx.
- slot_x  in  10  asteroid x; valid 1 cycle after slot_idx.
- slot_y  in  10  asteroid y; valid 1 cycle after slot_idx.
- slot_dir  in  6  asteroid direction; valid 1 cycle after slot_idx.
- slot_sprite  in  3  sprite select; valid 1 cycle after slot_idx.
- plot  out  1  one-cycle draw request to the draw stage.
- x_pos  out  10  latched asteroid x for the draw stage.
- y_pos  out  10  latched asteroid y for the draw stage.
- direction  out  6  latched direction.
- sprite_sel  out  3  latched sprite select.
- busy  out  1  high from the cycle after frame_start acceptance through DONE.
- frame_done  out  1  one-cycle pulse at end of pass.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0; state IDLE; wait counter 0.
- States: IDLE, FETCH, EVAL, PLOT, WAIT, NEXT, DONE.
- IDLE: on frame_start go to FETCH with slot_idx=0, busy=1. Otherwise hold.
- FETCH: slot_idx stable; table data arrives next cycle. Go to EVAL.
- EVAL:
  - If slot_active && slot_x<SCREEN_W && slot_y<SCREEN_H, register x_pos, y_pos, direction, sprite_sel and go to PLOT.
  - Otherwise go to NEXT, leaving the latched outputs unchanged.
- PLOT: plot=1 for exactly this cycle. Load counter with DRAW_CYCLES-1. Go to WAIT.
- WAIT: decrement the counter each cycle. At 0 go to NEXT. WAIT lasts exactly DRAW_CYCLES cycles.
- NEXT:
  - If slot_idx==NUM_SLOTS-1, go to DONE.
  - Else slot_idx+1 and go to FETCH.
  - slot_idx never wraps mid-pass.
- DONE: frame_done=1 for one cycle, slot_idx<=0, then IDLE; busy drops to 0 on entering IDLE.
- Latched outputs: x_pos, y_pos, direction, sprite_sel stay stable from EVAL through the end of WAIT; the draw stage may resample them at any time.
- Cycle cost per slot: inactive or culled = 3 cycles (FETCH, EVAL, NEXT); drawn = 4+DRAW_CYCLES = 1030.
- frame_start while busy (any state except IDLE): ignored for scheduling, overrun pulsed the same cycle. The pass continues unaffected.
- frame_start in the same cycle as DONE: counts as busy, so overrun=1 and no new pass starts.
- Edge coordinates: x=319 is drawn; x=320 is culled. No partial-clip logic here; pixel clipping belongs downstream.
- Reset mid-pass: immediate return to IDLE with all outputs 0, including plot.

Decomposition:
- Shared package asteroid_pkg holds:
  - SCREEN_W and SCREEN_H;
  - sprite size constant;
  - DRAW_CYCLES derivation;
  - state encoding enum.
- One natural sub-module: draw_wait_timer, a loadable down-counter with zero flag, reusable by other sprite schedulers (ship, bullets).

Test Plan:
- All 8 slots inactive, frame_start at cycle 0 -> plot never asserted; frame_done pulses at cycle 26; busy high cycles 1-25.
- Only slot 3 active at (100,50), dir 12, sprite 2 -> exactly one plot pulse with x_pos=100, y_pos=50, direction=12, sprite_sel=2; outputs stable 1026 cycles after plot; frame_done at cycle 26+1027.
- All 8 slots active on-screen -> 8 plot pulses spaced 1030 cycles apart; slot_idx sequence 0..7; single frame_done.
- Slot 0 at x=320, slot 1 at y=240, slot 2 at (319,239) -> only slot 2 plotted.
- frame_start re-pulsed during WAIT and during DONE -> overrun pulses each time; plot count and frame_done count unchanged.
- reset_n low during WAIT of slot 4 -> next edge all outputs 0, IDLE; fresh frame_start restarts from slot 0.
